// File: rtl/csr_trap_sequencer_pkg.sv
// csr_trap_sequencer_pkg: CSR indices, mstatus bit positions, FSM states and mstatus update helpers.
package csr_trap_sequencer_pkg;
    localparam logic [2:0] CSR_MSTATUS   = 3'd0;
    localparam logic [2:0] CSR_MTVEC     = 3'd1;
    localparam logic [2:0] CSR_MEPC      = 3'd2;
    localparam logic [2:0] CSR_MCAUSE    = 3'd3;
    localparam logic [2:0] CSR_MVENDORID = 3'd4;
    localparam logic [2:0] CSR_MARCHID   = 3'd5;
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_HI   = 12;
    localparam int MPP_LO   = 11;
    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC
    } state_t;
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MPIE_BIT] = s[MIE_BIT];
        r[MIE_BIT] = 1'b0;
        r[MPP_HI:MPP_LO] = 2'b11;
        return r;
    endfunction
    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MIE_BIT] = s[MPIE_BIT];
        r[MPIE_BIT] = 1'b1;
        r[MPP_HI:MPP_LO] = 2'b11;
        return r;
    endfunction
    // vendor/arch id registers are read-only to the pipeline
    function automatic logic is_ro(input logic [2:0] idx);
        return idx == CSR_MVENDORID || idx == CSR_MARCHID;
    endfunction
endpackage

// File: rtl/csr_trap_sequencer_if.sv
// csr_trap_sequencer_if: request, pipeline CSR traffic, CSR-file ports and redirect bundle.
interface csr_trap_sequencer_if;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_valid;
    logic        seq_ready;
    logic        wbu_csr_wr;
    logic [2:0]  wbu_csr_rd;
    logic [31:0] wbu_csr_data;
    logic [2:0]  idu_csr_rs;
    logic        pipe_stall;
    logic        csr_wr;
    logic [2:0]  csr_rd;
    logic [31:0] csr_busW;
    logic [2:0]  csr_rs;
    logic [31:0] csr_rs_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    modport slave (
        input  trap_valid, trap_pc, trap_cause, mret_valid,
        input  wbu_csr_wr, wbu_csr_rd, wbu_csr_data, idu_csr_rs, csr_rs_data,
        output seq_ready, pipe_stall, csr_wr, csr_rd, csr_busW, csr_rs,
        output redirect_valid, redirect_pc, flush
    );
    modport master (
        output trap_valid, trap_pc, trap_cause, mret_valid,
        output wbu_csr_wr, wbu_csr_rd, wbu_csr_data, idu_csr_rs, csr_rs_data,
        input  seq_ready, pipe_stall, csr_wr, csr_rd, csr_busW, csr_rs,
        input  redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/csr_trap_sequencer_wport_mux.sv
// csr_wport_mux: gives the CSR-file ports to the pipeline in idle and to the sequencer otherwise.
module csr_wport_mux
    import csr_trap_sequencer_pkg::*;
(
    input  logic        i_rst,
    input  logic        i_idle,
    input  logic        i_seq_wr,
    input  logic [2:0]  i_seq_rd,
    input  logic [31:0] i_seq_data,
    input  logic [2:0]  i_seq_rs,
    input  logic        i_wbu_wr,
    input  logic [2:0]  i_wbu_rd,
    input  logic [31:0] i_wbu_data,
    input  logic [2:0]  i_idu_rs,
    output logic        o_csr_wr,
    output logic [2:0]  o_csr_rd,
    output logic [31:0] o_csr_busw,
    output logic [2:0]  o_csr_rs
);
    always_comb begin
        o_csr_wr   = !i_rst && (i_idle ? (i_wbu_wr && !is_ro(i_wbu_rd)) : i_seq_wr);
        o_csr_rd   = i_idle ? i_wbu_rd : i_seq_rd;
        o_csr_busw = i_idle ? i_wbu_data : i_seq_data;
        o_csr_rs   = i_idle ? i_idu_rs : i_seq_rs;
    end
endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: walks mepc/mcause/mstatus/mtvec on a trap and mstatus/mepc on mret,
// then pulses a pipeline redirect; the pipeline is stalled while the walk owns the CSR ports.
module csr_trap_sequencer
    import csr_trap_sequencer_pkg::*;
(
    input logic clk,
    input logic rst,
    csr_trap_sequencer_if.slave bus
);
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_cause;
    logic        w_idle, w_seq_wr, w_redirect;
    logic [2:0]  w_seq_rd, w_seq_rs;
    logic [31:0] w_seq_data, w_redirect_pc;

    assign w_idle = r_state == IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle && bus.trap_valid) begin
                r_pc    <= bus.trap_pc;
                r_cause <= bus.trap_cause;
            end
        end
    end

    // trap wins over a simultaneous mret; the mret is simply not accepted
    always_comb begin
        w_next        = r_state;
        w_seq_wr      = 1'b0;
        w_seq_rd      = CSR_MSTATUS;
        w_seq_data    = '0;
        w_seq_rs      = CSR_MSTATUS;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        case (r_state)
            IDLE:    w_next = bus.trap_valid ? T_EPC : (bus.mret_valid ? M_STAT : IDLE);
            T_EPC: begin
                w_seq_wr   = 1'b1;
                w_seq_rd   = CSR_MEPC;
                w_seq_data = r_pc;
                w_next     = T_CAUSE;
            end
            T_CAUSE: begin
                w_seq_wr   = 1'b1;
                w_seq_rd   = CSR_MCAUSE;
                w_seq_data = r_cause;
                w_next     = T_STAT;
            end
            T_STAT: begin
                w_seq_wr   = 1'b1;
                w_seq_data = trap_mstatus(bus.csr_rs_data);
                w_next     = T_VEC;
            end
            T_VEC: begin
                w_seq_rs      = CSR_MTVEC;
                w_redirect    = 1'b1;
                w_redirect_pc = {bus.csr_rs_data[31:2], 2'b00};
                w_next        = IDLE;
            end
            M_STAT: begin
                w_seq_wr   = 1'b1;
                w_seq_data = mret_mstatus(bus.csr_rs_data);
                w_next     = M_EPC;
            end
            M_EPC: begin
                w_seq_rs      = CSR_MEPC;
                w_redirect    = 1'b1;
                w_redirect_pc = bus.csr_rs_data;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.seq_ready      = rst || w_idle;
    assign bus.pipe_stall     = !rst && !w_idle;
    assign bus.redirect_valid = !rst && w_redirect;
    assign bus.flush          = !rst && w_redirect;
    assign bus.redirect_pc    = w_redirect_pc;

    csr_wport_mux u_mux (
        .i_rst      (rst),
        .i_idle     (w_idle),
        .i_seq_wr   (w_seq_wr),
        .i_seq_rd   (w_seq_rd),
        .i_seq_data (w_seq_data),
        .i_seq_rs   (w_seq_rs),
        .i_wbu_wr   (bus.wbu_csr_wr),
        .i_wbu_rd   (bus.wbu_csr_rd),
        .i_wbu_data (bus.wbu_csr_data),
        .i_idu_rs   (bus.idu_csr_rs),
        .o_csr_wr   (bus.csr_wr),
        .o_csr_rd   (bus.csr_rd),
        .o_csr_busw (bus.csr_busW),
        .o_csr_rs   (bus.csr_rs)
    );
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: directed trap/mret/reset scenarios against a small CSR-file model.
module tb_csr_trap_sequencer;
    logic clk, rst;
    int n_cmp, n_err;
    logic [31:0] regs [0:7];

    csr_trap_sequencer_if bus();
    csr_trap_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.csr_rs_data = regs[bus.csr_rs];
    always @(posedge clk) if (bus.csr_wr) regs[bus.csr_rd] <= bus.csr_busW;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic wr, input logic rv, input logic st);
        chk1({tag, ".csr_wr"}, bus.csr_wr, wr);
        chk1({tag, ".redirect_valid"}, bus.redirect_valid, rv);
        chk1({tag, ".flush"}, bus.flush, rv);
        chk1({tag, ".pipe_stall"}, bus.pipe_stall, st);
        chk1({tag, ".seq_ready"}, bus.seq_ready, !st);
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic wbu(input logic wr, input logic [2:0] rd, input logic [31:0] d);
        bus.wbu_csr_wr = wr;
        bus.wbu_csr_rd = rd;
        bus.wbu_csr_data = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.trap_valid = 1'b0;
        bus.trap_pc = '0;
        bus.trap_cause = '0;
        bus.mret_valid = 1'b0;
        bus.idu_csr_rs = 3'd0;
        wbu(1'b1, 3'd1, 32'hdead_beef);
        cyc; cyc; #1;
        ctl("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc; wbu(1'b1, 3'd0, 32'h0000_1808); #1;
        ctl("wbu_pass", 1'b1, 1'b0, 1'b0);
        chk("wbu_pass.rd", 32'(bus.csr_rd), 32'd0);
        chk("wbu_pass.busW", bus.csr_busW, 32'h0000_1808);
        cyc; wbu(1'b1, 3'd1, 32'h8000_1001);
        cyc; wbu(1'b1, 3'd4, 32'h1234_5678); bus.idu_csr_rs = 3'd1; #1;
        chk1("wbu_ro4.csr_wr", bus.csr_wr, 1'b0);
        chk("idu_pass.rs", 32'(bus.csr_rs), 32'd1);
        chk("idu_pass.data", bus.csr_rs_data, 32'h8000_1001);
        cyc; wbu(1'b1, 3'd5, 32'h1); #1;
        chk1("wbu_ro5.csr_wr", bus.csr_wr, 1'b0);
        // trap entry with a WBU write to mtvec held through the sequence
        cyc; wbu(1'b0, 3'd0, 32'h0); bus.idu_csr_rs = 3'd0;
        bus.trap_valid = 1'b1; bus.trap_pc = 32'h8000_0010; bus.trap_cause = 32'hb; #1;
        ctl("trap_accept", 1'b0, 1'b0, 1'b0);
        cyc; bus.trap_valid = 1'b0; #1;
        ctl("t_epc", 1'b1, 1'b0, 1'b1);
        chk("t_epc.rd", 32'(bus.csr_rd), 32'd2);
        chk("t_epc.busW", bus.csr_busW, 32'h8000_0010);
        cyc; wbu(1'b1, 3'd1, 32'h100); #1;
        ctl("t_cause", 1'b1, 1'b0, 1'b1);
        chk("t_cause.rd", 32'(bus.csr_rd), 32'd3);
        chk("t_cause.busW", bus.csr_busW, 32'hb);
        cyc; #1;
        ctl("t_stat", 1'b1, 1'b0, 1'b1);
        chk("t_stat.rs", 32'(bus.csr_rs), 32'd0);
        chk("t_stat.rd", 32'(bus.csr_rd), 32'd0);
        chk("t_stat.busW", bus.csr_busW, 32'h0000_1880);
        cyc; #1;
        ctl("t_vec", 1'b0, 1'b1, 1'b1);
        chk("t_vec.rs", 32'(bus.csr_rs), 32'd1);
        chk("t_vec.redirect_pc", bus.redirect_pc, 32'h8000_1000);
        cyc; #1;
        ctl("trap_done", 1'b1, 1'b0, 1'b0);
        chk("trap_done.rd", 32'(bus.csr_rd), 32'd1);
        chk("trap_done.busW", bus.csr_busW, 32'h100);
        chk("mepc", regs[2], 32'h8000_0010);
        chk("mcause", regs[3], 32'hb);
        chk("mstatus_trap", regs[0], 32'h0000_1880);
        // mret
        cyc; wbu(1'b1, 3'd2, 32'h8000_0014);
        cyc; wbu(1'b0, 3'd0, 32'h0); bus.mret_valid = 1'b1; #1;
        ctl("mret_accept", 1'b0, 1'b0, 1'b0);
        cyc; bus.mret_valid = 1'b0; #1;
        ctl("m_stat", 1'b1, 1'b0, 1'b1);
        chk("m_stat.rd", 32'(bus.csr_rd), 32'd0);
        chk("m_stat.busW", bus.csr_busW, 32'h0000_1888);
        cyc; #1;
        ctl("m_epc", 1'b0, 1'b1, 1'b1);
        chk("m_epc.redirect_pc", bus.redirect_pc, 32'h8000_0014);
        cyc; #1;
        ctl("mret_done", 1'b0, 1'b0, 1'b0);
        chk("mstatus_mret", regs[0], 32'h0000_1888);
        // simultaneous trap and mret
        cyc; bus.trap_valid = 1'b1; bus.mret_valid = 1'b1;
        bus.trap_pc = 32'h8000_0020; bus.trap_cause = 32'h2;
        cyc; bus.trap_valid = 1'b0; bus.mret_valid = 1'b0; #1;
        ctl("both.t_epc", 1'b1, 1'b0, 1'b1);
        chk("both.t_epc.rd", 32'(bus.csr_rd), 32'd2);
        chk("both.t_epc.busW", bus.csr_busW, 32'h8000_0020);
        cyc; #1;
        chk("both.t_cause.busW", bus.csr_busW, 32'h2);
        cyc; #1;
        chk("both.t_stat.busW", bus.csr_busW, 32'h0000_1880);
        cyc; #1;
        ctl("both.t_vec", 1'b0, 1'b1, 1'b1);
        chk("both.redirect_pc", bus.redirect_pc, 32'h100);
        cyc; #1;
        ctl("both.idle", 1'b0, 1'b0, 1'b0);
        cyc; #1;
        ctl("both.no_mret", 1'b0, 1'b0, 1'b0);
        // reset during T_STAT
        cyc; bus.trap_valid = 1'b1; bus.trap_pc = 32'h8000_0030; bus.trap_cause = 32'h3;
        cyc; bus.trap_valid = 1'b0;
        cyc;
        cyc; rst = 1'b1; #1;
        ctl("rst_in_stat", 1'b0, 1'b0, 1'b0);
        cyc; rst = 1'b0; #1;
        ctl("after_rst", 1'b0, 1'b0, 1'b0);
        chk("after_rst.mstatus", regs[0], 32'h0000_1880);
        chk("after_rst.mepc", regs[2], 32'h8000_0030);
        cyc; #1;
        ctl("after_rst2", 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/csr_trap_sequencer.md
CSR_TRAP_SEQUENCER -- requirements
Module: csr_trap_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: trap_valid  in  1  ecall/exception request; trap_pc  in  32  faulting PC; trap_cause  in  32  mcause value.
REQ-003 SHALL have: mret_valid  in  1  mret request; seq_ready  out  1  high when a request can be accepted.
REQ-004 SHALL have: wbu_csr_wr  in  1; wbu_csr_rd  in  3; wbu_csr_data  in  32  normal CSR write from WBU.
REQ-005 SHALL have: idu_csr_rs  in  3  normal CSR read index; pipe_stall  out  1  holds IDU/WBU CSR traffic.
REQ-006 SHALL have: csr_wr  out  1; csr_rd  out  3; csr_busW  out  32  CSR-file write port.
REQ-007 SHALL have: csr_rs  out  3; csr_rs_data  in  32  CSR-file combinational read port.
REQ-008 SHALL have: redirect_valid  out  1; redirect_pc  out  32; flush  out  1  pipeline redirect.

Function
REQ-009 SHALL use CSR indices mstatus=0, mtvec=1, mepc=2, mcause=3, mvendorid=4, marchid=5.
REQ-010 SHALL implement FSM states IDLE, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC.
REQ-011 IDLE: seq_ready=1; trap_valid -> T_EPC, capture trap_pc/trap_cause; else mret_valid -> M_STAT.
REQ-012 Simultaneous trap_valid and mret_valid SHALL accept trap only; mret dropped.
REQ-013 T_EPC: csr_wr=1, csr_rd=2, csr_busW=captured pc -> T_CAUSE.
REQ-014 T_CAUSE: csr_wr=1, csr_rd=3, csr_busW=captured cause -> T_STAT.
REQ-015 T_STAT: csr_rs=0; write mstatus = read value with MPIE(bit7)<=MIE(bit3), MIE<=0, MPP(12:11)<=2'b11 -> T_VEC.
REQ-016 T_VEC: csr_rs=1; redirect_valid=1, flush=1, redirect_pc={csr_rs_data[31:2],2'b00}, no write -> IDLE.
REQ-017 M_STAT: csr_rs=0; write mstatus with MIE<=MPIE, MPIE<=1, MPP<=2'b11 -> M_EPC.
REQ-018 M_EPC: csr_rs=2; redirect_valid=1, flush=1, redirect_pc=csr_rs_data, no write -> IDLE.
REQ-019 Trap latency SHALL be 4 cycles accept-to-redirect; mret 2 cycles.
REQ-020 In IDLE, write port SHALL pass wbu_csr_* through, read port SHALL pass idu_csr_rs, pipe_stall=0.
REQ-021 Outside IDLE, pipe_stall=1, seq_ready=0, WBU writes blocked (csr_wr sequencer-owned), requests ignored.
REQ-022 WBU writes to index 4 or 5 SHALL be dropped (csr_wr=0).
REQ-023 WBU write in the accept cycle SHALL pass through; sequencer writes start next cycle.
REQ-024 redirect_valid and flush SHALL be single-cycle pulses.

Reset
REQ-025 rst SHALL force IDLE, clear captured pc/cause, and drive csr_wr=0, redirect_valid=0, flush=0, pipe_stall=0, seq_ready=1.
REQ-026 rst mid-sequence SHALL abort with no further CSR writes and no redirect.

Structure
REQ-027 Shared package SHALL hold CSR index constants, mstatus bit positions (MIE=3, MPIE=7, MPP=12:11) and FSM state enum.
REQ-028 One sub-module csr_wport_mux (write/read-port arbitration) is permitted; FSM in top.

Verification
REQ-029 Reset then trap_valid, pc=0x80000010, cause=0xb, mstatus=0x1808, mtvec=0x80001001 -> mepc=0x80000010, mcause=0xb, mstatus=0x1880, redirect_pc=0x80001000 four cycles after accept.
REQ-030 mret with mstatus=0x1880, mepc=0x80000014 -> mstatus=0x1888, redirect_pc=0x80000014 at cycle 2, one-cycle pulse.
REQ-031 trap_valid and mret_valid same cycle -> trap sequence only; mret produces no redirect.
REQ-032 WBU write mtvec=0x100 during T_CAUSE -> pipe_stall=1, write not visible on csr_wr until IDLE.
REQ-033 rst asserted in T_STAT -> mstatus unchanged, no redirect_valid, IDLE next cycle.
REQ-034 WBU write to index 4 in IDLE -> csr_wr=0.
